// File: rtl/bk_adder_arbiter.sv
// Shared 32-bit Brent-Kung adder with a round-robin arbiter in front of it.
// Multi-beat transactions chain the carry and hold the grant until the last beat.
// The result is registered behind a valid/ready handshake.

module brent_kung_adder (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Ci,
    output logic [31:0] S,
    output logic        Co
);
    logic [31:0] p;
    logic [31:0] gg;
    logic [31:0] pp;

    // Parallel-prefix carry network: up-sweep builds power-of-two spans, down-sweep fills the gaps.
    always_comb begin
        p  = A ^ B;
        gg = A & B;
        // Folding Ci into bit 0 lets every prefix generate act directly as a carry-out.
        gg[0] = gg[0] | (p[0] & Ci);
        pp = p;
        for (int unsigned l = 0; l < 5; l++) begin
            for (int unsigned i = (2 << l) - 1; i < 32; i += (2 << l)) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                pp[i] = pp[i] & pp[i - (1 << l)];
            end
        end
        for (int unsigned l = 4; l > 0; l--) begin
            for (int unsigned i = 3 * (1 << (l - 1)) - 1; i < 32; i += (2 << (l - 1))) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << (l - 1))]);
                pp[i] = pp[i] & pp[i - (1 << (l - 1))];
            end
        end
        S  = p ^ {gg[30:0], Ci};
        Co = gg[31];
    end
endmodule

module bk_adder_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_ci,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_co,
    output logic                     rsp_last
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [ID_W-1:0]  rr_ptr, rr_nxt;
    logic [ID_W-1:0]  owner, owner_nxt;
    logic [ID_W-1:0]  grant;
    logic             grant_ok;
    logic             can_issue;
    logic             accept;
    logic             carry_q;
    logic             ci_sel;
    logic             last_sel;
    logic [WIDTH-1:0] a_sel, b_sel, sum;
    logic             co;

    brent_kung_adder u_adder (
        .A  (a_sel),
        .B  (b_sel),
        .Ci (ci_sel),
        .S  (sum),
        .Co (co)
    );

    // Grant selection, ready generation, operand muxing and next-state decode.
    always_comb begin
        can_issue = !rsp_valid || rsp_ready;
        grant     = '0;
        grant_ok  = 1'b0;
        if (state == LOCKED) begin
            grant    = owner;
            grant_ok = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!grant_ok && req_valid[(32'(rr_ptr) + k) % NUM_REQ]) begin
                    grant    = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
                    grant_ok = 1'b1;
                end
            end
        end

        req_ready = '0;
        if (rst_n && grant_ok && can_issue) begin
            req_ready[grant] = 1'b1;
        end
        accept = |(req_ready & req_valid);

        a_sel    = '0;
        b_sel    = '0;
        last_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                a_sel    = req_a[i*WIDTH +: WIDTH];
                b_sel    = req_b[i*WIDTH +: WIDTH];
                last_sel = req_last[i];
            end
        end
        ci_sel = (state == LOCKED) ? carry_q : req_ci[grant];

        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        if (accept) begin
            if (last_sel) begin
                state_nxt = IDLE;
                rr_nxt    = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end else begin
                state_nxt = LOCKED;
                owner_nxt = grant;
            end
        end
    end

    // Arbiter state, chained carry and the registered result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            carry_q   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_co    <= 1'b0;
            rsp_last  <= 1'b0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
            if (accept) begin
                rsp_valid <= 1'b1;
                rsp_id    <= grant;
                rsp_sum   <= sum;
                rsp_co    <= co;
                rsp_last  <= last_sel;
                carry_q   <= co;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bk_adder_arbiter.sv
// Self-checking bench for bk_adder_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.

module tb_bk_adder_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, req_ci, req_last;
    logic [N*32-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready, rsp_co, rsp_last;
    logic [1:0]     rsp_id;
    logic [31:0]    rsp_sum;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bk_adder_arbiter #(.NUM_REQ(N), .ID_W(2), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ci(req_ci), .req_last(req_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_co(rsp_co), .rsp_last(rsp_last)
    );

    // Reference model: who holds the lock, where the round-robin search starts,
    // the carry owed to the next beat, and the result the DUT should present.
    bit          m_locked;
    int unsigned m_owner, m_rr;
    bit          m_carry;
    logic        m_vld, m_co, m_last;
    logic [1:0]  m_id;
    logic [31:0] m_sum;

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r = '0;
        if (!rst_n || (m_vld && !rsp_ready)) return r;
        if (m_locked) r[m_owner] = 1'b1;
        else
            for (int k = 0; k < N; k++)
                if (req_valid[(m_rr + k) % N]) begin
                    r[(m_rr + k) % N] = 1'b1;
                    break;
                end
        return r;
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] hit;
        int unsigned  g;
        logic [32:0]  s;
        if (!rst_n) begin
            m_locked = 0; m_owner = 0; m_rr = 0; m_carry = 0;
            m_vld = 0; m_id = 0; m_sum = 0; m_co = 0; m_last = 0;
        end else begin
            hit = model_ready() & req_valid;
            if (hit != 0) begin
                g = 0;
                for (int i = 0; i < N; i++) if (hit[i]) g = i;
                s = {1'b0, req_a[g*32 +: 32]} + {1'b0, req_b[g*32 +: 32]}
                    + 33'(m_locked ? m_carry : req_ci[g]);
                m_vld = 1; m_id = g[1:0]; m_sum = s[31:0]; m_co = s[32];
                m_last = req_last[g]; m_carry = s[32];
                if (req_last[g]) begin m_locked = 0; m_rr = (g + 1) % N; end
                else begin m_locked = 1; m_owner = g; end
            end else if (m_vld && rsp_ready) begin
                m_vld = 0;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [31:0] a, input logic [31:0] b,
                           input bit ci, input bit last);
        req_valid[i] = v; req_a[i*32 +: 32] = a; req_b[i*32 +: 32] = b;
        req_ci[i] = ci; req_last[i] = last;
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_a = '0; req_b = '0; req_ci = '0; req_last = '0;
    endtask

    task automatic test_reset();
        rst_n = 0; req_valid = '1; rsp_ready = 1; #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        cycle();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum} !== 37'h0) begin
            n_fail++; $display("FAIL reset_rsp: got v=%b id=%0d co=%b last=%b sum=%h expected all zero",
                                rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum);
        end
        clear_reqs(); rst_n = 1;
        cycle();
    endtask

    task automatic test_single();
        set_req(0, 1, 32'h1, 32'h1, 0, 1); #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single0_ready: got %b expected 0001", req_ready); end
        cycle(); clear_reqs();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum} !== {1'b1, 2'd0, 1'b0, 1'b1, 32'h2}) begin
            n_fail++; $display("FAIL single0_rsp: got v=%b id=%0d co=%b last=%b sum=%h expected 1/0/0/1/00000002",
                                rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum);
        end
        set_req(1, 1, 32'hFFFF_FFFF, 32'h1, 0, 1); #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single1_ready: got %b expected 0010", req_ready); end
        cycle(); clear_reqs();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum} !== {1'b1, 2'd1, 1'b1, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL single1_rsp: got v=%b id=%0d co=%b last=%b sum=%h expected 1/1/1/1/00000000",
                                rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum);
        end
        cycle();
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got rsp_valid=%b expected 0", rsp_valid); end
    endtask

    task automatic test_chain();
        set_req(3, 1, 32'h7, 32'h8, 0, 1);
        set_req(2, 1, 32'hFFFF_FFFF, 32'h1, 0, 0); #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL chain_b0_ready: got %b expected 0100", req_ready); end
        cycle();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum} !== {1'b1, 2'd2, 1'b1, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL chain_b0_rsp: got v=%b id=%0d co=%b last=%b sum=%h expected 1/2/1/0/00000000",
                                rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum);
        end
        req_valid[2] = 0;
        for (int b = 0; b < 2; b++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL chain_bubble_ready: got %b expected 0100", req_ready); end
            cycle();
            n_checks++;
            if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL chain_bubble_rsp: got rsp_valid=%b expected 0", rsp_valid); end
        end
        set_req(2, 1, 32'h0, 32'h0, 1, 1); #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL chain_b1_ready: got %b expected 0100", req_ready); end
        cycle(); req_valid[2] = 0;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum} !== {1'b1, 2'd2, 1'b0, 1'b1, 32'h1}) begin
            n_fail++; $display("FAIL chain_b1_rsp: got v=%b id=%0d co=%b last=%b sum=%h expected 1/2/0/1/00000001",
                                rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum);
        end
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL chain_r3_ready: got %b expected 1000", req_ready); end
        cycle(); clear_reqs();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum} !== {1'b1, 2'd3, 1'b0, 1'b1, 32'hF}) begin
            n_fail++; $display("FAIL chain_r3_rsp: got v=%b id=%0d co=%b last=%b sum=%h expected 1/3/0/1/0000000f",
                                rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  eid;
        logic [3:0]  erdy;
        logic [31:0] esum;
        for (int i = 0; i < 3; i++) set_req(i, 1, 32'd10, 32'd20, 0, 1);
        set_req(3, 1, 32'd15, 32'd1, 1, 1);
        for (int k = 0; k < 5; k++) begin
            eid  = 2'(k % 4);
            erdy = 4'(1 << (k % 4));
            esum = (eid == 2'd3) ? 32'h11 : 32'h1E;
            #1;
            n_checks++;
            if (req_ready !== erdy) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, erdy); end
            cycle();
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum} !== {1'b1, eid, 1'b0, 1'b1, esum}) begin
                n_fail++; $display("FAIL rr_rsp[%0d]: got v=%b id=%0d sum=%h expected 1/%0d/%h",
                                    k, rsp_valid, rsp_id, rsp_sum, eid, esum);
            end
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0000", c, req_ready); end
            cycle();
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum} !== {1'b1, 2'd0, 1'b0, 1'b1, 32'h1E}) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d sum=%h expected 1/0/0000001e",
                                    c, rsp_valid, rsp_id, rsp_sum);
            end
        end
        rsp_ready = 1; #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 0010", req_ready); end
        cycle(); clear_reqs();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum} !== {1'b1, 2'd1, 1'b0, 1'b1, 32'h1E}) begin
            n_fail++; $display("FAIL bp_release_rsp: got v=%b id=%0d sum=%h expected 1/1/0000001e",
                                rsp_valid, rsp_id, rsp_sum);
        end
    endtask

    task automatic test_reset_mid();
        set_req(1, 1, 32'hFFFF_FFFF, 32'h1, 0, 0); #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_lock_ready: got %b expected 0010", req_ready); end
        cycle();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum} !== {1'b1, 2'd1, 1'b1, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL mid_lock_rsp: got v=%b id=%0d co=%b last=%b sum=%h expected 1/1/1/0/00000000",
                                rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum);
        end
        rst_n = 0; #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 0000", req_ready); end
        cycle();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum} !== 37'h0) begin
            n_fail++; $display("FAIL mid_rst_rsp: got v=%b id=%0d co=%b last=%b sum=%h expected all zero",
                                rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum);
        end
        rst_n = 1;
        set_req(0, 1, 32'd5, 32'd6, 0, 1);
        set_req(1, 1, 32'd1, 32'd1, 0, 1); #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_post_ready: got %b expected 0001", req_ready); end
        cycle(); clear_reqs();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum} !== {1'b1, 2'd0, 1'b0, 1'b1, 32'd11}) begin
            n_fail++; $display("FAIL mid_post_rsp: got v=%b id=%0d co=%b sum=%h expected 1/0/0/0000000b",
                                rsp_valid, rsp_id, rsp_co, rsp_sum);
        end
        cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                set_req(i, $urandom_range(0, 2) != 0,
                        ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom(),
                        ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom(),
                        $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
            rsp_ready = $urandom_range(0, 3) != 0;
            #1;
            n_checks++;
            if (req_ready !== model_ready()) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, req_ready, model_ready());
            end
            cycle();
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum} !== {m_vld, m_id, m_co, m_last, m_sum}) begin
                n_fail++; $display("FAIL rand_rsp[%0d]: got v=%b id=%0d co=%b last=%b sum=%h expected v=%b id=%0d co=%b last=%b sum=%h",
                                    c, rsp_valid, rsp_id, rsp_co, rsp_last, rsp_sum, m_vld, m_id, m_co, m_last, m_sum);
            end
        end
        clear_reqs(); rsp_ready = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; rsp_ready = 0; clear_reqs();
        repeat (2) cycle();
        test_reset();
        test_single();
        test_chain();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
